// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a small PC-tagged queue feeding decode.
// Optional build macro FETCH_BYPASS_EN forwards a response that fills the head entry straight to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = PW + 2;

    logic [29:0]            fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]          head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [CW-1:0]          count_q, count_d, outst_q, outst_d;
    logic [DW-1:0]          drop_q, drop_d;
    logic [31:0]            ent_pc_q   [QUEUE_DEPTH];
    logic [31:0]            ent_pc_d   [QUEUE_DEPTH];
    logic [31:0]            ent_data_q [QUEUE_DEPTH];
    logic [31:0]            ent_data_d [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] ent_filled_q, ent_filled_d;
    logic                   req_en_q, req_en_d;
    logic                   valid_q, valid_d;
    logic [31:0]            instr_q, instr_d;
    logic [31:0]            pc_q, pc_d;

    logic req_fire_s, resp_use_s, resp_drop_s, bypass_s, pop_s;
    logic unused_s;

    // Only word addresses are fetched, so the byte offset of the restart PC is not used.
    assign unused_s = ^redirect_pc_i[1:0];

    // Handshake qualification for request, response, bypass and pop.
    always_comb begin
        imem_req_valid_o = req_en_q && !redirect_valid_i;
        imem_req_addr_o  = {fetch_pc_q, 2'b00};
        req_fire_s       = imem_req_valid_o && imem_req_ready_i;
        resp_drop_s      = imem_resp_valid_i && (drop_q != '0);
        resp_use_s       = imem_resp_valid_i && (drop_q == '0) && !redirect_valid_i;
`ifdef FETCH_BYPASS_EN
        bypass_s         = resp_use_s && (count_q != '0) && !ent_filled_q[head_q];
`else
        bypass_s         = 1'b0;
`endif
        instr_valid_o    = valid_q || bypass_s;
        instr_o          = bypass_s ? imem_resp_data_i : instr_q;
        pc_o             = bypass_s ? ent_pc_q[head_q] : pc_q;
        pop_s            = instr_valid_o && instr_ready_i && !redirect_valid_i;
    end

    // Queue, pointer and counter next-state; redirect flushes and re-targets fetch.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        head_d       = head_q;
        tail_d       = tail_q;
        fill_d       = fill_q;
        count_d      = count_q;
        outst_d      = outst_q;
        drop_d       = drop_q;
        ent_pc_d     = ent_pc_q;
        ent_data_d   = ent_data_q;
        ent_filled_d = ent_filled_q;
        if (redirect_valid_i) begin
            fetch_pc_d   = redirect_pc_i[31:2];
            head_d       = '0;
            tail_d       = '0;
            fill_d       = '0;
            count_d      = '0;
            outst_d      = '0;
            ent_filled_d = '0;
            // Everything still in flight, less a response landing now, must be discarded later.
            drop_d       = drop_q + DW'(outst_q) - DW'(imem_resp_valid_i);
        end else begin
            if (req_fire_s) begin
                ent_pc_d[tail_q]     = {fetch_pc_q, 2'b00};
                ent_filled_d[tail_q] = 1'b0;
                tail_d               = tail_q + PW'(1);
                fetch_pc_d           = fetch_pc_q + 30'd1;
            end else begin
                tail_d = tail_q;
            end
            if (resp_use_s) begin
                ent_data_d[fill_q]   = imem_resp_data_i;
                ent_filled_d[fill_q] = 1'b1;
                fill_d               = fill_q + PW'(1);
            end else begin
                fill_d = fill_q;
            end
            // Pop after fill so a bypassed head is released rather than left marked filled.
            if (pop_s) begin
                ent_filled_d[head_q] = 1'b0;
                head_d               = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            count_d = count_q + CW'(req_fire_s) - CW'(pop_s);
            outst_d = outst_q + CW'(req_fire_s) - CW'(resp_use_s);
            drop_d  = resp_drop_s ? (drop_q - DW'(1)) : drop_q;
        end
    end

    // Registered view of the head entry presented to decode; holds while the queue is empty.
    always_comb begin
        req_en_d = (count_d < CW'(QUEUE_DEPTH));
        valid_d  = (count_d != '0) && ent_filled_d[head_d];
        instr_d  = valid_d ? ent_data_d[head_d] : instr_q;
        pc_d     = valid_d ? ent_pc_d[head_d] : pc_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC[31:2];
            head_q       <= '0;
            tail_q       <= '0;
            fill_q       <= '0;
            count_q      <= '0;
            outst_q      <= '0;
            drop_q       <= '0;
            ent_pc_q     <= '{default: 32'h0000_0000};
            ent_data_q   <= '{default: 32'h0000_0000};
            ent_filled_q <= '0;
            req_en_q     <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= 32'h0000_0000;
            pc_q         <= 32'h0000_0000;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            fill_q       <= fill_d;
            count_q      <= count_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            ent_pc_q     <= ent_pc_d;
            ent_data_q   <= ent_data_d;
            ent_filled_q <= ent_filled_d;
            req_en_q     <= req_en_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
        end
    end

    fetch_unit_chk #(
        .CW (CW),
        .DW (DW)
    ) u_chk (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (imem_req_valid_o),
        .req_ready_i      (imem_req_ready_i),
        .req_addr_i       (imem_req_addr_o),
        .redirect_valid_i (redirect_valid_i),
        .resp_valid_i     (imem_resp_valid_i),
        .outst_i          (outst_q),
        .drop_i           (drop_q)
    );

endmodule

// fetch_unit_chk: protocol and counter-range properties for fetch_unit.
module fetch_unit_chk #(
    parameter int unsigned CW = 2,
    parameter int unsigned DW = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          req_valid_i,
    input logic          req_ready_i,
    input logic [31:0]   req_addr_i,
    input logic          redirect_valid_i,
    input logic          resp_valid_i,
    input logic [CW-1:0] outst_i,
    input logic [DW-1:0] drop_i
);

    localparam int unsigned SW = DW + 1;

    logic [SW-1:0] inflight_s;

    // Responses still owed to the core after this cycle, in a width that cannot wrap.
    assign inflight_s = SW'(drop_i) + SW'(outst_i) - SW'(resp_valid_i);

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid_i |-> ((outst_i != '0) || (drop_i != '0)));

    a_drop_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        redirect_valid_i |-> (inflight_s <= SW'((1 << DW) - 1)));

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid_i && !req_ready_i) |=> (!req_valid_i || $stable(req_addr_i)));

    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid_i && !req_ready_i) |=> (req_valid_i || redirect_valid_i));

endmodule
